// File: rtl/cpu_simd_unit.sv
// SIMD vector unit: four LANES*WORD vector registers and a word-addressed memory.
// Every clock edge executes one of load, store, lane-wise add or lane-wise multiply.
module cpu_simd_unit #(
   parameter int WORD  = 32,
   parameter int LANES = 16,
   parameter int DEPTH = 512
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 select,
   input  logic [1:0]                 regnumber,
   input  logic [$clog2(DEPTH)-1:0]   madd,
   output logic [LANES*WORD-1:0]      a,
   output logic [LANES*WORD-1:0]      b,
   output logic [LANES*WORD-1:0]      s0,
   output logic [LANES*WORD-1:0]      s1,
   output logic [LANES*WORD-1:0]      mem,
   output logic [LANES*WORD-1:0]      register
);

   localparam int VW = LANES * WORD;
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_ADD   = 2'b10,
      OP_MUL   = 2'b11
   } op_e;

   op_e              op;
   logic [VW-1:0]    regs_q [4];
   logic [VW-1:0]    regs_d [4];
   logic [WORD-1:0]  mem_q  [DEPTH];
   logic [AW-1:0]    lane_addr [LANES];
   logic [VW-1:0]    mem_vec;
   logic [VW-1:0]    add_lo;
   logic [VW-1:0]    add_hi;
   logic [VW-1:0]    mul_lo;
   logic [VW-1:0]    mul_hi;

   assign op = op_e'(select);

   // Lane addresses wrap naturally because madd is exactly AW bits wide.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [WORD:0]     sum;
         logic [2*WORD-1:0] prod;

         assign lane_addr[gi] = madd + AW'(gi);
         assign mem_vec[gi*WORD +: WORD] = mem_q[lane_addr[gi]];

         assign sum  = {1'b0, regs_q[0][gi*WORD +: WORD]}
                     + {1'b0, regs_q[1][gi*WORD +: WORD]};
         assign prod = {{WORD{1'b0}}, regs_q[0][gi*WORD +: WORD]}
                     * {{WORD{1'b0}}, regs_q[1][gi*WORD +: WORD]};

         assign add_lo[gi*WORD +: WORD] = sum[WORD-1:0];
         assign add_hi[gi*WORD +: WORD] = {{(WORD-1){1'b0}}, sum[WORD]};
         assign mul_lo[gi*WORD +: WORD] = prod[WORD-1:0];
         assign mul_hi[gi*WORD +: WORD] = prod[2*WORD-1:WORD];
      end
   endgenerate

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         regs_d[r] = regs_q[r];
      end
      case (op)
         OP_LOAD: regs_d[regnumber] = mem_vec;
         OP_ADD: begin
            regs_d[2] = add_lo;
            regs_d[3] = add_hi;
         end
         OP_MUL: begin
            regs_d[2] = mul_lo;
            regs_d[3] = mul_hi;
         end
         default: ;
      endcase
   end

   // Reset preloads memory with its own addresses so loads have known data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < 4; r++) begin
            regs_q[r] <= '0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= WORD'(i);
         end
      end else begin
         for (int r = 0; r < 4; r++) begin
            regs_q[r] <= regs_d[r];
         end
         if (op == OP_STORE) begin
            for (int k = 0; k < LANES; k++) begin
               mem_q[lane_addr[k]] <= regs_q[regnumber][k*WORD +: WORD];
            end
         end
      end
   end

   assign a        = regs_q[0];
   assign b        = regs_q[1];
   assign s0       = regs_q[2];
   assign s1       = regs_q[3];
   assign mem      = mem_vec;
   assign register = regs_q[regnumber];

endmodule

// File: tb/tb_cpu_simd_unit.sv
// Directed bench for cpu_simd_unit: load/store, add/multiply with carries,
// address wrap and mid-sequence reset, with hand-derived expected vectors.
module tb_cpu_simd_unit;

   localparam int VW = 512;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    select;
   logic [1:0]    regnumber;
   logic [8:0]    madd;
   logic [VW-1:0] a, b, s0, s1, mem, register;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_simd_unit #(.WORD(32), .LANES(16), .DEPTH(512)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .select    (select),
      .regnumber (regnumber),
      .madd      (madd),
      .a         (a),
      .b         (b),
      .s0        (s0),
      .s1        (s1),
      .mem       (mem),
      .register  (register)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Vector whose lane k holds (start+k) mod 512, i.e. the reset memory image.
   function automatic logic [VW-1:0] seq_vec(input int start);
      logic [VW-1:0] v;
      for (int k = 0; k < 16; k++) begin
         v[k*32 +: 32] = 32'((start + k) % 512);
      end
      return v;
   endfunction

   function automatic logic [VW-1:0] lane(input logic [VW-1:0] v, input int k);
      return VW'(v[k*32 +: 32]);
   endfunction

   task automatic step(input logic [1:0] sel, input logic [1:0] rn, input int ad);
      select    = sel;
      regnumber = rn;
      madd      = 9'(ad);
      @(posedge clk);
      @(negedge clk);
      $display("op=%0d reg=%0d madd=%0d rst_n=%0b a0=%0h b0=%0h s0_0=%0h s1_0=%0h",
               sel, rn, ad, rst_n, a[31:0], b[31:0], s0[31:0], s1[31:0]);
   endtask

   task automatic peek_mem(input int ad);
      madd = 9'(ad);
      #1;
   endtask

   logic [VW-1:0] exp_s0, exp_s1, exp_v;
   logic [63:0]   p;

   initial begin
      rst_n = 1'b0; select = 2'b00; regnumber = 2'd0; madd = 9'd0;

      // Reset state
      step(2'b00, 2'd0, 0);
      check("rst_a",  a,  '0);
      check("rst_b",  b,  '0);
      check("rst_s0", s0, '0);
      check("rst_s1", s1, '0);
      peek_mem(0);
      check("rst_mem0", mem, seq_vec(0));
      peek_mem(510);
      check("rst_mem510_wrap", mem, seq_vec(510));
      rst_n = 1'b1;

      // Loads
      step(2'b00, 2'd0, 278);
      check("load_r0_278", a, seq_vec(278));
      check("load_r0_lane0", lane(a, 0), VW'(32'h116));
      check("load_r0_lane15", lane(a, 15), VW'(32'h125));
      step(2'b00, 2'd1, 345);
      check("load_r1_345", b, seq_vec(345));
      check("load_r1_lane15", lane(b, 15), VW'(32'h168));

      // Add: lane k = 623 + 2k, no carry
      step(2'b10, 2'd0, 0);
      for (int k = 0; k < 16; k++) exp_s0[k*32 +: 32] = 32'(623 + 2*k);
      check("add_s0", s0, exp_s0);
      check("add_s0_lane0", lane(s0, 0), VW'(32'h26F));
      check("add_s1_zero", s1, '0);
      check("add_a_kept", a, seq_vec(278));

      // Multiply
      step(2'b11, 2'd0, 0);
      for (int k = 0; k < 16; k++) begin
         p = 64'(278 + k) * 64'(345 + k);
         exp_s0[k*32 +: 32] = p[31:0];
         exp_s1[k*32 +: 32] = p[63:32];
      end
      check("mul_s0", s0, exp_s0);
      check("mul_s0_lane0", lane(s0, 0), VW'(32'h000176A6));
      check("mul_s1", s1, exp_s1);
      regnumber = 2'd2; #1;
      check("regout_r2", register, exp_s0);

      // Store R0 @33, reload into R1
      step(2'b01, 2'd0, 33);
      step(2'b00, 2'd1, 33);
      check("store_load_b", b, seq_vec(278));
      peek_mem(33);
      check("store_mem33", mem, seq_vec(278));
      exp_v = seq_vec(277);
      exp_v[31:0] = 32'd32;
      peek_mem(32);
      check("store_mem32_edge", mem, exp_v);
      regnumber = 2'd1; #1;
      check("regout_r1", register, b);
      check("regout_r1_val", register, seq_vec(278));

      // Build 0xFFFFFFFF = 65535 * 65537 in lane 0
      step(2'b00, 2'd0, 255);
      step(2'b00, 2'd1, 257);
      step(2'b11, 2'd0, 0);
      check("mul_65535", lane(s0, 0), VW'(32'd65535));
      step(2'b01, 2'd2, 100);
      step(2'b00, 2'd0, 256);
      step(2'b00, 2'd1, 256);
      step(2'b11, 2'd0, 0);
      check("mul_65536", lane(s0, 0), VW'(32'd65536));
      step(2'b01, 2'd2, 120);
      step(2'b00, 2'd0, 120);
      step(2'b00, 2'd1, 1);
      step(2'b10, 2'd0, 0);
      check("add_65537", lane(s0, 0), VW'(32'd65537));
      step(2'b01, 2'd2, 140);
      step(2'b00, 2'd0, 100);
      step(2'b00, 2'd1, 140);
      step(2'b11, 2'd0, 0);
      check("mul_allones", lane(s0, 0), VW'(32'hFFFFFFFF));
      step(2'b01, 2'd2, 0);
      step(2'b01, 2'd2, 16);
      step(2'b00, 2'd0, 0);
      step(2'b00, 2'd1, 16);
      check("carry_a0", lane(a, 0), VW'(32'hFFFFFFFF));
      check("carry_b0", lane(b, 0), VW'(32'hFFFFFFFF));
      step(2'b10, 2'd0, 0);
      check("carry_add_s0", lane(s0, 0), VW'(32'hFFFFFFFE));
      check("carry_add_s1", lane(s1, 0), VW'(32'd1));
      step(2'b11, 2'd0, 0);
      check("carry_mul_s0", lane(s0, 0), VW'(32'h00000001));
      check("carry_mul_s1", lane(s1, 0), VW'(32'hFFFFFFFE));

      // Reset during a multiply sequence
      rst_n = 1'b0;
      step(2'b11, 2'd0, 0);
      check("midrst_a",  a,  '0);
      check("midrst_b",  b,  '0);
      check("midrst_s0", s0, '0);
      check("midrst_s1", s1, '0);
      peek_mem(0);
      check("midrst_mem0", mem, seq_vec(0));
      rst_n = 1'b1;

      // Address wrap on load and store
      step(2'b00, 2'd0, 500);
      check("wrap_load_a", a, seq_vec(500));
      check("wrap_lane12", lane(a, 12), VW'(32'd0));
      step(2'b01, 2'd0, 505);
      peek_mem(505);
      check("wrap_store_mem505", mem, seq_vec(500));
      step(2'b00, 2'd3, 505);
      check("load_r3_wrap", s1, seq_vec(500));

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
